// File: rtl/dmem_cache_pkg.sv
// dmem_cache_pkg: shared constants, FSM encoding and line record for the data cache
package dmem_cache_pkg;
  localparam int ADDR_W = 7;
  localparam int LINES = 8;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [31:0] data;
  } line_t;
endpackage

// File: rtl/dmem_cache_array.sv
// dmem_cache_array: valid/tag/data storage, 1 async read port, 1 write port, valid cleared on reset
module dmem_cache_array import dmem_cache_pkg::*; #(
  parameter int LINES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output line_t            rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  line_t            wr_line
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag [LINES];
  logic [31:0] data [LINES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (wr_en) valid[wr_idx] <= wr_line.valid;
  always_ff @(posedge clk)
    if (wr_en) begin
      tag[wr_idx] <= wr_line.tag;
      data[wr_idx] <= wr_line.data;
    end
  assign rd_line = '{valid: valid[rd_idx], tag: tag[rd_idx], data: data[rd_idx]};
endmodule

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped write-through, write-no-allocate data cache between CPU and word memory
module dmem_cache import dmem_cache_pkg::*; #(
  parameter int LINES = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  state_t state, next;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [ADDR_W-1:0] look_addr;
  line_t rd_line, wr_line;
  logic hit, idle_hit, idle_miss, wr_en;
  // IDLE looks up the live CPU address; every other state looks up the latched one
  assign look_addr = (state == IDLE) ? proc_addr : lat_addr;
  assign hit = rd_line.valid && rd_line.tag == look_addr[ADDR_W-1:IDX_W];
  assign idle_hit = state == IDLE && proc_read && !proc_write && hit;
  assign idle_miss = state == IDLE && (proc_write || (proc_read && !hit));
  assign wr_en = mem_ready && (state == RD_MISS || (state == WR_THRU && hit));
  assign wr_line = '{valid: 1'b1, tag: lat_addr[ADDR_W-1:IDX_W],
                     data: (state == RD_MISS) ? mem_rdata : lat_wdata};
  dmem_cache_array #(.LINES(LINES)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .rd_idx(look_addr[IDX_W-1:0]),
    .rd_line(rd_line),
    .wr_en(wr_en),
    .wr_idx(lat_addr[IDX_W-1:0]),
    .wr_line(wr_line)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lat_addr <= '0;
      lat_wdata <= '0;
    end else begin
      state <= next;
      if (idle_miss) lat_addr <= proc_addr;
      if (state == IDLE && proc_write) lat_wdata <= proc_wdata;
    end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = proc_write ? WR_THRU : idle_miss ? RD_MISS : IDLE;
      RD_MISS: next = mem_ready ? DONE : RD_MISS;
      WR_THRU: next = mem_ready ? DONE : WR_THRU;
      DONE:    next = IDLE;
    endcase
  end
  // stall is gated by rst_n so it reads 0 while reset is held, whatever the CPU drives
  always_comb begin
    proc_stall = rst_n && (idle_miss || state == RD_MISS || state == WR_THRU);
    proc_rdata = (idle_hit || state == DONE) ? rd_line.data : '0;
    mem_read = state == RD_MISS;
    mem_write = state == WR_THRU;
    mem_addr = (mem_read || mem_write) ? lat_addr : '0;
    mem_wdata = mem_write ? lat_wdata : '0;
  end
endmodule
